// File: rtl/eda_pixel_stack_if.sv
// Push/pop channel bundle for the pixel address stack.
// master = flood controller side, slave = stack side.
interface eda_pixel_stack_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int NB         = 8
);
  logic                  push_valid;
  logic                  push_ready;
  logic [NB-1:0]         push_positions;
  logic [ADDR_WIDTH-1:0] upleft_addr;
  logic [ADDR_WIDTH-1:0] up_addr;
  logic [ADDR_WIDTH-1:0] upright_addr;
  logic [ADDR_WIDTH-1:0] left_addr;
  logic [ADDR_WIDTH-1:0] right_addr;
  logic [ADDR_WIDTH-1:0] downleft_addr;
  logic [ADDR_WIDTH-1:0] down_addr;
  logic [ADDR_WIDTH-1:0] downright_addr;
  logic                  pop_valid;
  logic                  pop_ready;
  logic [ADDR_WIDTH-1:0] pop_addr;

  modport master (
    output push_valid, push_positions,
    output upleft_addr, up_addr, upright_addr, left_addr,
    output right_addr, downleft_addr, down_addr, downright_addr,
    output pop_ready,
    input  push_ready, pop_valid, pop_addr
  );

  modport slave (
    input  push_valid, push_positions,
    input  upleft_addr, up_addr, upright_addr, left_addr,
    input  right_addr, downleft_addr, down_addr, downright_addr,
    input  pop_ready,
    output push_ready, pop_valid, pop_addr
  );
endinterface

// File: rtl/eda_pixel_stack.sv
// LIFO of pixel addresses for the region-maximum flood.
// Serialises an 8-neighbour push vector into the stack, one entry per cycle.
module eda_pixel_stack #(
  parameter int M            = 16,
  parameter int N            = 16,
  parameter int WINDOW_WIDTH = 9,
  parameter int ADDR_WIDTH   = $clog2(M*N),
  parameter int DEPTH        = M*N,
  parameter int CNT_WIDTH    = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  eda_pixel_stack_if.slave     px,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow
);

  localparam int NB    = WINDOW_WIDTH - 1;
  localparam int SEL_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pend_addr [NB];
  logic [ADDR_WIDTH-1:0] addr_in [NB];
  logic [NB-1:0]         pend_vec;
  logic [NB-1:0]         pend_rest;
  logic [SEL_W-1:0]      sel;
  logic [CNT_WIDTH-1:0]  top;
  logic                  push_fire;
  logic                  pop_fire;
  logic                  load;
  logic                  wr_en;

  assign addr_in[7] = px.upleft_addr;
  assign addr_in[6] = px.up_addr;
  assign addr_in[5] = px.upright_addr;
  assign addr_in[4] = px.left_addr;
  assign addr_in[3] = px.right_addr;
  assign addr_in[2] = px.downleft_addr;
  assign addr_in[1] = px.down_addr;
  assign addr_in[0] = px.downright_addr;

  assign empty = (count == '0);
  assign full  = (count == CNT_WIDTH'(DEPTH));
  assign top   = count - 1'b1;

  assign px.push_ready = (state == IDLE);
  assign px.pop_valid  = (state == IDLE) && !empty;
  assign px.pop_addr   = empty ? '0 : mem[top[IDX_W-1:0]];

  assign push_fire = px.push_ready && px.push_valid;
  assign pop_fire  = px.pop_valid && px.pop_ready;
  assign wr_en     = load && !full && !clear;

  // Highest pending bit wins: ascending scan, last hit sticks.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NB; k++) begin
      if (pend_vec[k]) sel = SEL_W'(k);
    end
    pend_rest      = pend_vec;
    pend_rest[sel] = 1'b0;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (push_fire && (px.push_positions != '0)) state_nx = LOAD;
      end
      LOAD: begin
        load = 1'b1;
        if (pend_rest == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      pend_vec <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      count    <= '0;
      pend_vec <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop_fire) count <= count - 1'b1;
      if (push_fire) pend_vec <= px.push_positions;
      if (load) begin
        pend_vec <= pend_rest;
        if (full) overflow <= 1'b1;
        else      count    <= count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[count[IDX_W-1:0]] <= pend_addr[sel];
    if (push_fire && !clear) begin
      for (int k = 0; k < NB; k++) pend_addr[k] <= addr_in[k];
    end
  end

endmodule

// File: tb/tb_eda_pixel_stack.sv
// Directed bench for eda_pixel_stack.
// Main instance at DEPTH=256, second at DEPTH=4 for full/overflow.
module tb_eda_pixel_stack;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clr0 = 1'b0;
  logic clr1 = 1'b0;

  logic [8:0] cnt0;
  logic [2:0] cnt1;
  logic emp0, full0, ovf0;
  logic emp1, full1, ovf1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eda_pixel_stack_if #(.ADDR_WIDTH(8), .NB(8)) b0 ();
  eda_pixel_stack_if #(.ADDR_WIDTH(8), .NB(8)) b1 ();

  eda_pixel_stack u0 (
    .clk(clk), .reset_n(reset_n), .clear(clr0), .px(b0),
    .count(cnt0), .empty(emp0), .full(full0), .overflow(ovf0)
  );

  eda_pixel_stack #(.DEPTH(4)) u1 (
    .clk(clk), .reset_n(reset_n), .clear(clr1), .px(b1),
    .count(cnt1), .empty(emp1), .full(full1), .overflow(ovf1)
  );

  task automatic chk(string tag, int unsigned got, int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addrs0(input logic [7:0] a [8]);
    b0.upleft_addr    = a[7];
    b0.up_addr        = a[6];
    b0.upright_addr   = a[5];
    b0.left_addr      = a[4];
    b0.right_addr     = a[3];
    b0.downleft_addr  = a[2];
    b0.down_addr      = a[1];
    b0.downright_addr = a[0];
  endtask

  // Presents one vector for one cycle, returns cycles spent with push_ready low.
  task automatic push0(input logic [7:0] vec, output int loads);
    b0.push_valid     = 1'b1;
    b0.push_positions = vec;
    tick();
    b0.push_valid = 1'b0;
    loads = 0;
    while (!b0.push_ready && loads < 20) begin
      loads++;
      tick();
    end
  endtask

  logic [7:0] a [8];
  int n;

  initial begin
    b0.push_valid = 1'b0; b0.push_positions = '0; b0.pop_ready = 1'b0;
    b1.push_valid = 1'b0; b1.push_positions = '0; b1.pop_ready = 1'b0;
    for (int k = 0; k < 8; k++) a[k] = 8'hEE;
    set_addrs0(a);
    b1.upleft_addr = 8'h10; b1.up_addr = 8'h11;
    b1.upright_addr = 8'h12; b1.left_addr = 8'h13;
    b1.right_addr = 8'h14; b1.downleft_addr = 8'h15;
    b1.down_addr = 8'h16; b1.downright_addr = 8'h17;

    repeat (2) tick();
    chk("rst_push_ready", b0.push_ready, 1);
    chk("rst_pop_valid", b0.pop_valid, 0);
    chk("rst_empty", emp0, 1);
    chk("rst_count", cnt0, 0);
    chk("rst_overflow", ovf0, 0);
    chk("rst_full", full0, 0);
    chk("rst_pop_addr", b0.pop_addr, 0);
    reset_n = 1'b1;
    tick();

    // two-bit vector
    a[7] = 8'h11; a[0] = 8'h33;
    set_addrs0(a);
    push0(8'b1000_0001, n);
    chk("v81_loads", n, 2);
    chk("v81_count", cnt0, 2);
    chk("v81_top", b0.pop_addr, 8'h33);
    b0.pop_ready = 1'b1;
    tick();
    chk("v81_pop2", b0.pop_addr, 8'h11);
    tick();
    b0.pop_ready = 1'b0;
    chk("v81_empty", emp0, 1);
    chk("v81_pop_valid", b0.pop_valid, 0);

    // all eight bits, bit7 = 0x10
    for (int k = 0; k < 8; k++) a[k] = 8'(8'h17 - k);
    set_addrs0(a);
    push0(8'hFF, n);
    chk("vff_loads", n, 8);
    chk("vff_count", cnt0, 8);
    b0.pop_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("vff_pop%0d", k), b0.pop_addr, 8'h17 - k);
      tick();
    end
    b0.pop_ready = 1'b0;
    chk("vff_empty", emp0, 1);

    // zero vector
    push0(8'h00, n);
    chk("v00_loads", n, 0);
    chk("v00_count", cnt0, 0);
    chk("v00_ready", b0.push_ready, 1);

    // count=3 top=0xA5, then pop and push together
    a[7] = 8'h01; a[6] = 8'h02; a[5] = 8'hA5; a[1] = 8'h42;
    set_addrs0(a);
    push0(8'b1110_0000, n);
    chk("sim_pre_count", cnt0, 3);
    chk("sim_pre_top", b0.pop_addr, 8'hA5);
    b0.pop_ready = 1'b1;
    b0.push_valid = 1'b1;
    b0.push_positions = 8'b0000_0010;
    tick();
    b0.pop_ready = 1'b0;
    b0.push_valid = 1'b0;
    chk("sim_mid_count", cnt0, 2);
    chk("sim_mid_ready", b0.push_ready, 0);
    tick();
    chk("sim_count", cnt0, 3);
    chk("sim_top", b0.pop_addr, 8'h42);
    b0.pop_ready = 1'b1;
    tick();
    b0.pop_ready = 1'b0;
    chk("sim_after_pop", b0.pop_addr, 8'h02);

    // clear mid-LOAD abandons the remaining bits
    b0.push_valid = 1'b1;
    b0.push_positions = 8'hFF;
    tick();
    b0.push_valid = 1'b0;
    tick();
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("clr_count", cnt0, 0);
    chk("clr_ready", b0.push_ready, 1);
    tick();
    chk("clr_stays_empty", cnt0, 0);

    // DEPTH=4 overflow
    b1.push_valid = 1'b1;
    b1.push_positions = 8'hFF;
    tick();
    b1.push_valid = 1'b0;
    n = 0;
    while (!b1.push_ready && n < 20) begin
      n++;
      tick();
    end
    chk("d4_loads", n, 8);
    chk("d4_count", cnt1, 4);
    chk("d4_full", full1, 1);
    chk("d4_overflow", ovf1, 1);
    chk("d4_top", b1.pop_addr, 8'h13);
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    chk("d4_clr_count", cnt1, 0);
    chk("d4_clr_overflow", ovf1, 0);
    chk("d4_clr_empty", emp1, 1);
    chk("d4_clr_full", full1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
